obstacle_lane_scheduler: RTL and testbench

//  Sequences the obstacle lanes for the game: owns the movement time base, speed tier and

---
 rtl/obstacle_lane_scheduler.sv | 148 ++++++++++++++
 tb/tb_obstacle_lane_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_lane_scheduler.sv
// Obstacle lane scheduler: movement time base, speed tier, direction pattern and
// a round-robin one-hot step strobe shared by the lane position logic.
module obstacle_lane_scheduler #(
   parameter int         c_NB_LANES     = 4,
   parameter int         c_BASE_PERIOD  = 781250,
   parameter int         c_FREEZE_TICKS = 32,
   parameter logic [7:0] c_LFSR_SEED    = 8'hA5
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_N,
   input  logic                  i_Start,
   input  logic                  i_Collision,
   input  logic                  i_Level_Req,
   input  logic [5:0]            i_Score,
   output logic [c_NB_LANES-1:0] o_Step,
   output logic [c_NB_LANES-1:0] o_Reverse,
   output logic                  o_Level_Up,
   output logic [1:0]            o_Speed_Tier,
   output logic [1:0]            o_State
);

   localparam logic [19:0] c_PERIOD = 20'(c_BASE_PERIOD);
   localparam int          c_FW     = $clog2(c_FREEZE_TICKS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LEVEL = 2'd2,
      ST_HIT   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [19:0]       r_count;
   logic [19:0]       w_period;
   logic              w_tick;
   logic [1:0]        w_tier;
   logic [7:0]        r_lfsr;
   logic [7:0]        w_lfsr_next;
   logic [c_FW-1:0]   r_freeze;
   logic              w_do_level;
   logic              w_do_sweep;
   logic              w_restart;

   assign o_State     = r_state;
   assign w_period    = c_PERIOD >> o_Speed_Tier;
   assign w_tick      = ((r_state == ST_RUN) || (r_state == ST_LEVEL)) &&
                        (r_count == (w_period - 20'd1));
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   always_comb begin
      w_tier = 2'd3;
      if (i_Score <= 6'd3)
         w_tier = 2'd0;
      else if (i_Score <= 6'd6)
         w_tier = 2'd1;
      else if (i_Score <= 6'd9)
         w_tier = 2'd2;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // In RUN a collision beats a level request, which beats a movement tick.
   always_comb begin
      w_next_state = r_state;
      w_do_level   = 1'b0;
      w_do_sweep   = 1'b0;
      w_restart    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_Start) begin
               w_next_state = ST_RUN;
               w_restart    = 1'b1;
            end
         end
         ST_RUN: begin
            if (i_Collision)
               w_next_state = ST_HIT;
            else if (i_Level_Req) begin
               w_next_state = ST_LEVEL;
               w_do_level   = 1'b1;
            end else if (w_tick)
               w_do_sweep = 1'b1;
         end
         ST_LEVEL: begin
            if (i_Collision)
               w_next_state = ST_HIT;
            else if (w_tick && (r_freeze == c_FW'(1)))
               w_next_state = ST_RUN;
         end
         ST_HIT: begin
            if (i_Start) begin
               w_next_state = ST_RUN;
               w_restart    = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         r_count      <= '0;
         o_Speed_Tier <= 2'd0;
         r_freeze     <= '0;
         r_lfsr       <= c_LFSR_SEED;
         o_Reverse    <= '0;
         o_Level_Up   <= 1'b0;
         o_Step       <= '0;
      end else begin
         o_Level_Up <= w_do_level;

         if ((w_next_state == ST_IDLE) || (w_next_state == ST_HIT) || w_tick || w_restart)
            r_count <= '0;
         else
            r_count <= r_count + 20'd1;

         // The tier only changes at a period boundary so a period is never cut short.
         if (w_tick || w_restart)
            o_Speed_Tier <= w_tier;

         if (w_do_level)
            r_freeze <= c_FW'(c_FREEZE_TICKS);
         else if ((r_state == ST_LEVEL) && w_tick && (r_freeze != '0))
            r_freeze <= r_freeze - c_FW'(1);

         if (w_do_level) begin
            r_lfsr    <= w_lfsr_next;
            o_Reverse <= w_lfsr_next[c_NB_LANES-1:0];
         end else if (w_restart)
            o_Reverse <= '0;

         // One-hot walks up one lane per cycle and falls off the top after the last lane.
         if (w_do_sweep)
            o_Step <= c_NB_LANES'(1);
         else if ((r_state == ST_RUN) && (w_next_state == ST_RUN))
            o_Step <= o_Step << 1;
         else
            o_Step <= '0;
      end
   end

endmodule

// File: tb/tb_obstacle_lane_scheduler.sv
// Randomized bench for obstacle_lane_scheduler, checked every cycle against a
// cycle-level reference model of the game phases, time base and sweep schedule.
module tb_obstacle_lane_scheduler;

   localparam int c_LANES  = 4;
   localparam int c_BASE   = 16;
   localparam int c_FREEZE = 2;

   logic       i_Clk       = 1'b0;
   logic       i_Rst_N     = 1'b0;
   logic       i_Start     = 1'b0;
   logic       i_Collision = 1'b0;
   logic       i_Level_Req = 1'b0;
   logic [5:0] i_Score     = 6'd0;
   logic [c_LANES-1:0] o_Step;
   logic [c_LANES-1:0] o_Reverse;
   logic       o_Level_Up;
   logic [1:0] o_Speed_Tier;
   logic [1:0] o_State;

   int checkCount = 0;
   int errorCount = 0;

   int         m_state;
   int         m_cnt;
   int         m_tier;
   int         m_freeze;
   int         m_edge;
   int         m_tickEdge;
   bit         m_live;
   bit         m_lvlUp;
   logic [7:0] m_lfsr;
   logic [3:0] m_rev;
   logic [5:0] score;

   always #5 i_Clk = ~i_Clk;

   obstacle_lane_scheduler #(
      .c_NB_LANES    (c_LANES),
      .c_BASE_PERIOD (c_BASE),
      .c_FREEZE_TICKS(c_FREEZE),
      .c_LFSR_SEED   (8'hA5)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Rst_N     (i_Rst_N),
      .i_Start     (i_Start),
      .i_Collision (i_Collision),
      .i_Level_Req (i_Level_Req),
      .i_Score     (i_Score),
      .o_Step      (o_Step),
      .o_Reverse   (o_Reverse),
      .o_Level_Up  (o_Level_Up),
      .o_Speed_Tier(o_Speed_Tier),
      .o_State     (o_State)
   );

   function automatic int tierOf(input int s);
      if (s < 4) return 0;
      if (s < 7) return 1;
      if (s < 10) return 2;
      return 3;
   endfunction

   // Lane k fires k edges after the edge that sampled the tick, unless aborted.
   function automatic logic [3:0] expStep();
      int k;
      k = m_edge - m_tickEdge;
      if (m_live && (k >= 0) && (k < c_LANES))
         return 4'(1 << k);
      return 4'd0;
   endfunction

   task automatic modelReset();
      m_state    = 0;
      m_cnt      = 0;
      m_tier     = 0;
      m_freeze   = 0;
      m_edge     = 0;
      m_tickEdge = -100;
      m_live     = 0;
      m_lvlUp    = 0;
      m_lfsr     = 8'hA5;
      m_rev      = 4'd0;
   endtask

   task automatic modelEdge();
      int  per;
      int  nxt;
      bit  tick;
      bit  restart;
      logic fb;
      m_edge++;
      per     = c_BASE / (2 ** m_tier);
      tick    = ((m_state == 1) || (m_state == 2)) && (m_cnt == per - 1);
      restart = 0;
      nxt     = m_state;
      m_lvlUp = 0;
      case (m_state)
         0: if (i_Start) begin nxt = 1; restart = 1; end
         1: begin
            if (i_Collision) begin
               nxt = 3; m_live = 0;
            end else if (i_Level_Req) begin
               nxt = 2; m_lvlUp = 1; m_live = 0; m_freeze = c_FREEZE;
               fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
               m_lfsr = {m_lfsr[6:0], fb};
               m_rev  = m_lfsr[3:0];
            end else if (tick) begin
               m_live = 1; m_tickEdge = m_edge;
            end
         end
         2: begin
            if (i_Collision)
               nxt = 3;
            else if (tick) begin
               m_freeze--;
               if (m_freeze == 0) nxt = 1;
            end
         end
         default: if (i_Start) begin nxt = 1; restart = 1; m_rev = 4'd0; end
      endcase
      if (tick || restart)
         m_tier = tierOf(int'(i_Score));
      if ((nxt == 0) || (nxt == 3) || tick || restart)
         m_cnt = 0;
      else
         m_cnt++;
      m_state = nxt;
   endtask

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
      end
   endtask

   task automatic compareAll();
      checkOutput("step",    int'(o_Step),       int'(expStep()));
      checkOutput("state",   int'(o_State),      m_state);
      checkOutput("levelUp", int'(o_Level_Up),   int'(m_lvlUp));
      checkOutput("reverse", int'(o_Reverse),    int'(m_rev));
      checkOutput("tier",    int'(o_Speed_Tier), m_tier);
   endtask

   task automatic applyStimulus(input bit s, input bit c, input bit l, input logic [5:0] sc);
      i_Start     = s;
      i_Collision = c;
      i_Level_Req = l;
      i_Score     = sc;
      @(posedge i_Clk);
      modelEdge();
      @(negedge i_Clk);
      compareAll();
   endtask

   initial begin
      bit found;
      modelReset();
      repeat (2) @(negedge i_Clk);
      compareAll();
      i_Rst_N = 1'b1;

      $display("[TB] idle: start held low with random collision/level/score");
      for (int i = 0; i < 200; i++)
         applyStimulus(1'b0, 1'($urandom % 2), 1'($urandom % 2), 6'($urandom));

      $display("[TB] run at tier 0");
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 40; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);

      $display("[TB] score raised mid-period");
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 40; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);

      $display("[TB] level-up freeze");
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd5);
      checkOutput("levelReverseA", int'(o_Reverse), 'hA);
      checkOutput("levelPulse", int'(o_Level_Up), 1);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd5);
      checkOutput("noSecondPulse", int'(o_Level_Up), 0);
      for (int i = 0; i < 30; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);

      $display("[TB] collision mid-sweep");
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (expStep() == 4'b0010) found = 1;
         else applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);
      end
      checkOutput("sweep0010", int'(o_Step), 'b0010);
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd5);
      checkOutput("hitState", int'(o_State), 3);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd5);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd5);

      $display("[TB] random play");
      score = 6'd0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom % 50 == 0) score = 6'($urandom % 16);
         applyStimulus(1'($urandom % 40 == 0), 1'($urandom % 60 == 0),
                       1'($urandom % 25 == 0), score);
      end

      $display("[TB] async reset during LEVEL");
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd2);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd2);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd2);
      checkOutput("inLevel", int'(o_State), 2);
      #2 i_Rst_N = 1'b0;
      #1;
      checkOutput("rstState",   int'(o_State),      0);
      checkOutput("rstStep",    int'(o_Step),       0);
      checkOutput("rstReverse", int'(o_Reverse),    0);
      checkOutput("rstLevelUp", int'(o_Level_Up),   0);
      checkOutput("rstTier",    int'(o_Speed_Tier), 0);
      modelReset();
      @(negedge i_Clk);
      compareAll();
      i_Rst_N = 1'b1;
      for (int i = 0; i < 30; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd2);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
